// File: rtl/crc_pkg.sv
// crc_pkg: shared FSM state type and USB CRC-5 default constants
package crc_pkg;
  typedef enum logic [1:0] {IDLE, DATA, CRC} crc_state_t;
  localparam logic [4:0] USB5_POLY    = 5'b00101;
  localparam logic [4:0] USB5_INIT    = 5'b11111;
  localparam logic [4:0] USB5_RESIDUE = 5'b01100;
endpackage

// File: rtl/crc_lfsr.sv
// crc_lfsr: MSB-first CRC shift register with optional plain-shift mode
module crc_lfsr
  import crc_pkg::*;
#(
  parameter int                  CRC_BITS = 5,
  parameter logic [CRC_BITS-1:0] POLY     = USB5_POLY,
  parameter logic [CRC_BITS-1:0] INIT     = USB5_INIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic                bit_in,
  input  logic                shift_only,
  output logic [CRC_BITS-1:0] crc_out
);
  logic [CRC_BITS-1:0] r_crc;
  logic                w_fb;
  assign w_fb    = !shift_only && (r_crc[CRC_BITS-1] ^ bit_in);
  assign crc_out = r_crc;
  // reload on reset or frame end, otherwise step once per enabled bit
  always_ff @(posedge clk) begin
    if (!rst || clr) r_crc <= INIT;
    else if (en) r_crc <= {r_crc[CRC_BITS-2:0], 1'b0} ^ (w_fb ? POLY : '0);
  end
endmodule

// File: rtl/crc_serial_tx.sv
// crc_serial_tx: serial pass-through that appends a CRC and self-checks the frame
module crc_serial_tx
  import crc_pkg::*;
#(
  parameter int                  DATA_BITS = 11,
  parameter int                  CRC_BITS  = 5,
  parameter logic [CRC_BITS-1:0] POLY      = USB5_POLY,
  parameter logic [CRC_BITS-1:0] INIT      = '1,
  parameter bit                  INVERT    = 1'b1,
  parameter logic [CRC_BITS-1:0] RESIDUE   = USB5_RESIDUE
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic out_data,
  output logic out_last,
  output logic ok
);
  localparam int MAXB = DATA_BITS > CRC_BITS ? DATA_BITS : CRC_BITS;
  localparam int CW   = $clog2(MAXB);
  crc_state_t          r_state, w_state_next;
  logic [CW-1:0]       r_cnt, w_cnt_next;
  logic                r_ok;
  logic [CRC_BITS-1:0] w_crc, w_chk, w_chk_next;
  logic                w_crc_st, w_xfer, w_last_data, w_end;
  assign w_crc_st    = rst && r_state == CRC;
  assign in_ready    = !w_crc_st && out_ready;
  assign out_valid   = w_crc_st || in_valid;
  assign out_data    = w_crc_st ? w_crc[CRC_BITS-1] ^ INVERT : in_data;
  assign out_last    = w_crc_st && r_cnt == CW'(CRC_BITS-1);
  assign w_xfer      = out_valid && out_ready;
  assign w_last_data = r_cnt == CW'(DATA_BITS-1);
  assign w_end       = w_xfer && out_last;
  assign w_chk_next  = {w_chk[CRC_BITS-2:0], 1'b0} ^ ((w_chk[CRC_BITS-1] ^ out_data) ? POLY : '0);
  assign ok          = r_ok;
  crc_lfsr #(.CRC_BITS(CRC_BITS), .POLY(POLY), .INIT(INIT)) u_gen (
    .clk(clk), .rst(rst), .en(w_xfer), .clr(w_end), .bit_in(in_data),
    .shift_only(w_crc_st), .crc_out(w_crc)
  );
  crc_lfsr #(.CRC_BITS(CRC_BITS), .POLY(POLY), .INIT(INIT)) u_chk (
    .clk(clk), .rst(rst), .en(w_xfer), .clr(w_end), .bit_in(out_data),
    .shift_only(1'b0), .crc_out(w_chk)
  );
  // state, bit counter and registered residue-match pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ok    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ok    <= w_end && w_chk_next == RESIDUE;
    end
  end
  // advance only on a transfer: payload count into CRC emission, then back to IDLE
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (w_xfer && w_crc_st) begin
      w_state_next = out_last ? IDLE : CRC;
      w_cnt_next   = out_last ? '0 : r_cnt + 1'b1;
    end else if (w_xfer) begin
      w_state_next = w_last_data ? CRC : DATA;
      w_cnt_next   = w_last_data ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_crc_serial_tx.sv
// tb_crc_serial_tx: directed vectors for the USB CRC-5 transmitter plus a CRC-8 variant
module tb_crc_serial_tx;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_data = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_data, out_last, ok;
  logic in_valid2 = 1'b0, in_data2 = 1'b0, out_ready2 = 1'b1;
  logic in_ready2, out_valid2, out_data2, out_last2, ok2;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [10:0] pl;
    int          mode;
    logic [4:0]  crc;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  crc_serial_tx dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .ok(ok)
  );

  crc_serial_tx #(
    .DATA_BITS(1), .CRC_BITS(8), .POLY(8'h07), .INIT(8'h00), .INVERT(1'b0), .RESIDUE(8'h00)
  ) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_last(out_last2), .ok(ok2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // mode 0: ready always high; 1: ready toggles starting low; 2: 3-cycle in_valid gap after 4 bits
  task automatic frame(input logic [10:0] pl, input int mode, output logic [15:0] bits,
                       output int ncyc, output int lastcnt, output int last_idx,
                       output logic ok_after, output int okcnt);
    int idx = 0, gap = 0;
    logic hv = 1'b0, hd = 1'b0, hl = 1'b0, gapc;
    bits = '0; ncyc = 0; lastcnt = 0; last_idx = -1; okcnt = 0;
    while (idx < 16 && ncyc < 200) begin
      #1;
      gapc      = mode == 2 && idx == 4 && gap < 3;
      out_ready = mode == 1 ? (ncyc % 2 == 1) : 1'b1;
      in_valid  = !gapc;
      in_data   = idx < 11 ? pl[10-idx] : 1'b0;
      #1;
      if (ncyc > 0 && ok) okcnt++;
      if (gapc) chk("gap_out_valid", out_valid, 0);
      if (idx >= 11) chk("crc_in_ready", in_ready, 0);
      else chk("data_in_ready", in_ready, out_ready);
      if (hv) begin
        chk("stall_data", out_data, hd);
        chk("stall_last", out_last, hl);
      end
      hv = idx >= 11 && !out_ready;
      hd = out_data;
      hl = out_last;
      if (out_valid && out_ready) begin
        bits[15-idx] = out_data;
        if (out_last) begin
          lastcnt++;
          last_idx = idx;
        end
        idx++;
      end
      @(posedge clk);
      ncyc++;
      if (gapc) gap++;
    end
    #1 ok_after = ok;
  endtask

  task automatic run_bits(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic check_frame(input string nm, input logic [10:0] pl, input int mode,
                             input logic [4:0] crc);
    logic [15:0] bits;
    int ncyc, lastcnt, last_idx, okcnt;
    logic ok_after;
    frame(pl, mode, bits, ncyc, lastcnt, last_idx, ok_after, okcnt);
    chk({nm, "_bits"}, bits, {pl, crc});
    chk({nm, "_cycles"}, ncyc, mode == 1 ? 32 : mode == 2 ? 19 : 16);
    chk({nm, "_last_cnt"}, lastcnt, 1);
    chk({nm, "_last_idx"}, 32'(last_idx), 15);
    chk({nm, "_ok"}, ok_after, 1);
    chk({nm, "_ok_extra"}, okcnt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] b2;
    int i2, c2, l2;
    tbl[0] = '{11'h000, 0, 5'b01000};
    tbl[1] = '{11'h000, 1, 5'b01000};
    tbl[2] = '{11'h7FF, 0, 5'b00010};
    tbl[3] = '{11'h000, 2, 5'b01000};
    tbl[4] = '{11'h7FF, 1, 5'b00010};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ok", ok, 0);
    chk("rst_last", out_last, 0);
    chk("rst_in_ready_hi", in_ready, 1);
    chk("rst_out_valid_lo", out_valid, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    #1;
    chk("rst_in_ready_lo", in_ready, 0);
    chk("rst_out_valid_hi", out_valid, 1);
    in_valid = 1'b0;
    rst      = 1'b1;
    for (int i = 0; i < 5; i++) check_frame($sformatf("vec%0d", i), tbl[i].pl, tbl[i].mode, tbl[i].crc);
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("ok_clear", ok, 0);
    run_bits(6);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("abort6_in_ready", in_ready, 1);
    chk("abort6_out_valid", out_valid, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    chk("abort6_ok", ok, 0);
    check_frame("after6", 11'h000, 0, 5'b01000);
    run_bits(15);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("abort15_out_valid", out_valid, 0);
    chk("abort15_out_last", out_last, 0);
    chk("abort15_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    chk("abort15_ok", ok, 0);
    check_frame("after15", 11'h7FF, 0, 5'b00010);
    b2 = '0; i2 = 0; c2 = 0; l2 = 0;
    while (i2 < 9 && c2 < 50) begin
      #1;
      in_valid2  = 1'b1;
      in_data2   = i2 == 0;
      out_ready2 = 1'b1;
      #1;
      if (i2 > 0) chk("w8_in_ready", in_ready2, 0);
      if (out_valid2 && out_ready2) begin
        b2[8-i2] = out_data2;
        if (out_last2) l2++;
        i2++;
      end
      @(posedge clk);
      c2++;
    end
    #1;
    chk("w8_bits", b2, 9'b1_0000_0111);
    chk("w8_last", l2, 1);
    chk("w8_cycles", c2, 9);
    chk("w8_ok", ok2, 1);
    in_valid2 = 1'b0;
    @(posedge clk);
    #1 chk("w8_ok_clear", ok2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
